count_tick_sched: RTL and testbench

Central tick scheduler for the hex-counter display design. It derives one-cycle clock-enable strobes from the 100 MHz system clock rather than generating divided clocks. It also owns the run/stop/single-step sequencing of the counter and the user-selectable count rate. It replaces per-consumer divided clocks: the hex counter consumes `cnt_tick` and the 7-segment digit multiplexer consumes `scan_tick`, both in the `clkin` domain.

---
 rtl/count_tick_sched_pkg.sv | 33 +++
 rtl/count_tick_sched_if.sv | 27 ++
 rtl/count_tick_sched_mod_prescaler.sv | 47 ++++
 rtl/count_tick_sched.sv | 120 ++++++++++++
 tb/tb_count_tick_sched.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/count_tick_sched_pkg.sv
`default_nettype none
// ============================================================================
// tick_pkg : shared types, rate constants and divisor helper for count_tick_sched
// Rev 1.0
// ============================================================================
package tick_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        RELOAD = 2'd3
    } sched_state_t;

    typedef logic [1:0] rate_t;

    localparam int unsigned RATE_HZ_0 = 1;
    localparam int unsigned RATE_HZ_1 = 2;
    localparam int unsigned RATE_HZ_2 = 5;
    localparam int unsigned RATE_HZ_3 = 10;

    // Truncating integer division; evaluated at elaboration time.
    function automatic int unsigned rate_div(input int unsigned clk_hz, input rate_t rate);
        case (rate)
            2'd0:    return clk_hz / RATE_HZ_0;
            2'd1:    return clk_hz / RATE_HZ_1;
            2'd2:    return clk_hz / RATE_HZ_2;
            default: return clk_hz / RATE_HZ_3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_tick_sched_if.sv
`default_nettype none
// ============================================================================
// count_tick_sched_if : control inputs and tick/status outputs of the scheduler
// Rev 1.0
// ============================================================================
interface count_tick_sched_if;

    tick_pkg::rate_t rate_sel;
    logic            run_tgl;
    logic            step_req;
    logic            cnt_tick;
    logic            scan_tick;
    logic            running;
    logic [1:0]      state_o;

    modport slave (
        input  rate_sel, run_tgl, step_req,
        output cnt_tick, scan_tick, running, state_o
    );

    modport master (
        output rate_sel, run_tgl, step_req,
        input  cnt_tick, scan_tick, running, state_o
    );

endinterface
`default_nettype wire

// File: rtl/count_tick_sched_mod_prescaler.sv
`default_nettype none
// ============================================================================
// mod_prescaler : modulo-div counter with enable, clear and registered terminal strobe
// Rev 1.0
// ============================================================================
module mod_prescaler #(
    parameter int unsigned DIV_W = 27
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    input  wire logic             clr,
    input  wire logic [DIV_W-1:0] div,
    output logic                  tc
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             w_at_tc;

    // The strobe is raised whenever an enabled count leaves terminal count,
    // even if that same edge clears the counter (stop/reload coincident tick).
    always_comb begin
        w_at_tc = (cnt_q == div - DIV_W'(1));
        cnt_d   = cnt_q;
        tc_d    = en && w_at_tc;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = w_at_tc ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign tc = tc_q;

endmodule
`default_nettype wire

// File: rtl/count_tick_sched.sv
`default_nettype none
// ============================================================================
// count_tick_sched : count/scan clock-enable scheduler with run/stop/step and rate select
// Rev 1.0
// ============================================================================
module count_tick_sched
    import tick_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 1000,
    parameter int unsigned DIV_W   = 27
) (
    input  wire logic         clkin,
    input  wire logic         rst_n,
    count_tick_sched_if.slave bus
);

    localparam logic [DIV_W-1:0] c_div_0    = DIV_W'(rate_div(CLK_HZ, 2'd0));
    localparam logic [DIV_W-1:0] c_div_1    = DIV_W'(rate_div(CLK_HZ, 2'd1));
    localparam logic [DIV_W-1:0] c_div_2    = DIV_W'(rate_div(CLK_HZ, 2'd2));
    localparam logic [DIV_W-1:0] c_div_3    = DIV_W'(rate_div(CLK_HZ, 2'd3));
    localparam logic [DIV_W-1:0] c_scan_div = DIV_W'(CLK_HZ / SCAN_HZ);

    sched_state_t     state_q, state_d;
    rate_t            rate_q, rate_d;
    logic             ret_run_q, ret_run_d;
    logic             step_q, step_d;
    logic             w_rate_chg;
    logic             w_cnt_en;
    logic             w_cnt_clr;
    logic             w_cnt_tc;
    logic             w_scan_tc;
    logic [DIV_W-1:0] w_cnt_div;

    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        ret_run_d  = ret_run_q;
        w_rate_chg = (bus.rate_sel != rate_q);
        case (state_q)
            IDLE: begin
                if (bus.run_tgl) begin
                    state_d = RUN;
                end else if (w_rate_chg) begin
                    state_d   = RELOAD;
                    ret_run_d = 1'b0;
                end else if (bus.step_req) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (bus.run_tgl) begin
                    state_d = IDLE;
                end else if (w_rate_chg) begin
                    state_d   = RELOAD;
                    ret_run_d = 1'b1;
                end
            end
            STEP: state_d = IDLE;
            RELOAD: begin
                rate_d  = bus.rate_sel;
                state_d = ret_run_q ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        step_d = (state_d == STEP);
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rate_q    <= '0;
            ret_run_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rate_q    <= rate_d;
            ret_run_q <= ret_run_d;
            step_q    <= step_d;
        end
    end

    always_comb begin
        case (rate_q)
            2'd0:    w_cnt_div = c_div_0;
            2'd1:    w_cnt_div = c_div_1;
            2'd2:    w_cnt_div = c_div_2;
            default: w_cnt_div = c_div_3;
        endcase
    end

    // Stopping clears the count so a later restart always begins a full period.
    assign w_cnt_en  = (state_q == RUN);
    assign w_cnt_clr = (state_q == RELOAD) || ((state_q == RUN) && bus.run_tgl);

    mod_prescaler #(.DIV_W(DIV_W)) u_cnt_pre (
        .clk   (clkin),
        .rst_n (rst_n),
        .en    (w_cnt_en),
        .clr   (w_cnt_clr),
        .div   (w_cnt_div),
        .tc    (w_cnt_tc)
    );

    mod_prescaler #(.DIV_W(DIV_W)) u_scan_pre (
        .clk   (clkin),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .div   (c_scan_div),
        .tc    (w_scan_tc)
    );

    assign bus.cnt_tick  = w_cnt_tc | step_q;
    assign bus.scan_tick = w_scan_tc;
    assign bus.running   = (state_q == RUN);
    assign bus.state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_count_tick_sched.sv
`default_nettype none
// ============================================================================
// tb_count_tick_sched : directed + random stimulus checked against an edge-count reference model
// Rev 1.0
// ============================================================================
module tb_count_tick_sched;
    import tick_pkg::*;

    localparam int unsigned CLK_HZ  = 100;
    localparam int unsigned SCAN_HZ = 10;
    localparam int unsigned DIV_W   = 27;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    count_tick_sched_if bus ();

    count_tick_sched #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .DIV_W   (DIV_W)
    ) dut (
        .clkin (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ticks are placed by modular arithmetic on absolute edge numbers.
    int e           = 0;
    int m_state     = 0;
    int m_rate      = 0;
    int m_ret       = 0;
    int anchor      = 0;
    int scan_anchor = 0;
    int exp_cnt     = 0;
    int exp_scan    = 0;
    int cur_rate    = 0;
    int rate_hz [4] = '{1, 2, 5, 10};

    function automatic int mdiv(input int r);
        return int'(CLK_HZ) / rate_hz[r];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, e, got, exp);
        end
    endtask

    task automatic model_edge(input logic rn, input int rs, input logic rt, input logic sr);
        int prev;
        if (!rn) begin
            m_state     = 0;
            m_rate      = 0;
            m_ret       = 0;
            anchor      = e;
            scan_anchor = e;
            exp_cnt     = 0;
            exp_scan    = 0;
        end else begin
            exp_scan = (((e - scan_anchor) % int'(CLK_HZ / SCAN_HZ)) == 0) ? 1 : 0;
            prev     = m_state;
            exp_cnt  = (prev == 1 && ((e - anchor) % mdiv(m_rate)) == 0) ? 1 : 0;
            case (prev)
                0: begin
                    if (rt) begin
                        m_state = 1;
                        anchor  = e;
                    end else if (rs != m_rate) begin
                        m_state = 3;
                        m_ret   = 0;
                    end else if (sr) begin
                        m_state = 2;
                    end
                end
                1: begin
                    if (rt) m_state = 0;
                    else if (rs != m_rate) begin
                        m_state = 3;
                        m_ret   = 1;
                    end
                end
                2: m_state = 0;
                default: begin
                    m_rate  = rs;
                    m_state = m_ret ? 1 : 0;
                    anchor  = e;
                end
            endcase
            if (m_state == 2) exp_cnt = 1;
        end
    endtask

    task automatic cyc(input logic rn, input logic rt, input logic sr);
        rst_n        = rn;
        bus.rate_sel = rate_t'(cur_rate);
        bus.run_tgl  = rt;
        bus.step_req = sr;
        @(posedge clk);
        e++;
        model_edge(rn, cur_rate, rt, sr);
        #1;
        chk("cnt_tick",  32'(bus.cnt_tick),  32'(exp_cnt));
        chk("scan_tick", 32'(bus.scan_tick), 32'(exp_scan));
        chk("state_o",   32'(bus.state_o),   32'(m_state));
        chk("running",   32'(bus.running),   32'(m_state == 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int guard;
        bus.rate_sel = '0;
        bus.run_tgl  = 1'b0;
        bus.step_req = 1'b0;

        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
        idle(300);

        cur_rate = 3;
        idle(3);
        cyc(1'b1, 1'b1, 1'b0);
        idle(35);
        cyc(1'b1, 1'b1, 1'b0);
        idle(3);

        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            idle(4);
        end

        cur_rate = 0;
        idle(3);
        cyc(1'b1, 1'b1, 1'b0);
        idle(36);
        cur_rate = 2;
        idle(100);
        cyc(1'b1, 1'b1, 1'b0);
        idle(3);

        // Toggle and step together from IDLE: toggle wins.
        cyc(1'b1, 1'b1, 1'b1);
        idle(25);

        // Stop on the edge where the period completes.
        guard = 0;
        while (((e + 1 - anchor) % mdiv(m_rate)) != 0 && guard < 200) begin
            idle(1);
            guard++;
        end
        cyc(1'b1, 1'b1, 1'b0);
        idle(30);

        // Reset during RUN, then during STEP.
        cyc(1'b1, 1'b1, 1'b0);
        idle(15);
        cyc(1'b0, 1'b0, 1'b0);
        idle(30);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        idle(15);

        for (int i = 0; i < 3000; i++) begin
            logic rn, rt, sr;
            rn = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 149) == 0) cur_rate = int'($urandom_range(0, 3));
            rt = ($urandom_range(0, 59) == 0);
            sr = ($urandom_range(0, 9) == 0);
            cyc(rn, rt, sr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
